seq_code_tx: RTL and testbench
==============================

Name: seq_code_tx

Overview:
- Transmitter side of the 4-digit code-sequence interface; the companion detector FSM watches for this sequence.
- Serially emits the 4-bit digit code CODE0, CODE1, CODE2, CODE3 (default 1, 4, 6, 9) one digit per accepted transfer.
- Repeats the code a requested number of times, with optional idle gaps between code words.
- Feeds the detector, or any digit-stream consumer, through a valid/ready handshake.

Parameters:
CODE0, 4'd1, first digit of the code word
CODE1, 4'd4, second digit
CODE2, 4'd6, third digit
CODE3, 4'd9, fourth digit
FILL, 4'd0, digit driven on data_o whenever valid_o=0 (must not equal CODE0)
GAP, 2, idle cycles between consecutive code words (0..15; 0 = back-to-back)

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous reset, active-high
start_i  input  1  begin transmission; sampled only in IDLE
count_i  input  8  number of code words to send; latched with start_i
abort_i  input  1  terminate transmission immediately
ready_i  input  1  consumer accepts the current digit
data_o  output  4  current digit
valid_o  output  1  data_o holds a code digit
digit_idx_o  output  2  position (0..3) of data_o within the code word
busy_o  output  1  high in SEND or GAP
done_o  output  1  one-cycle pulse when the final digit has been accepted

Behaviour:
- Reset (synchronous, rst_i=1 at an edge): state IDLE, data_o=FILL, valid_o=0, digit_idx_o=0, busy_o=0, done_o=0. Internal word counter=0, gap counter=0. Reset overrides every other input.
- All outputs are registered or decoded from registered state. No combinational path from any input to any output.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - start_i=1 and count_i!=0: latch count_i into words_left, idx=0, go SEND. First digit appears on the cycle after start_i is sampled (1-cycle latency).
  - start_i=1 and count_i=0: go DONE. done_o pulses with no digits sent.
- SEND:
  - valid_o=1, data_o=CODE[idx], digit_idx_o=idx, busy_o=1.
  - While ready_i=0: data_o and digit_idx_o stay stable.
  - Transfer = valid_o && ready_i at an edge.
  - On transfer with idx<3: idx++.
  - On transfer with idx=3: idx=0, words_left--.
    - If words_left was 1: go DONE.
    - Else if GAP=0: stay in SEND, next word starts the next cycle.
    - Else: load gap counter with GAP, go GAP.
- GAP: valid_o=0, data_o=FILL, busy_o=1. Gap counter decrements each cycle; when it reaches 1, go SEND. GAP lasts exactly GAP cycles; ready_i is ignored.
- DONE: lasts exactly one cycle with done_o=1, busy_o=0, valid_o=0, data_o=FILL; then IDLE.
- abort_i=1 in SEND or GAP: go IDLE next cycle, no done_o pulse. abort_i beats a simultaneous transfer, so that digit is not counted as sent. abort_i is ignored in IDLE and DONE.
- start_i outside IDLE is ignored; count_i is not re-latched.
- count_i=255 sends 1020 digits with no wrap or overflow; words_left is 8 bits and never underflows.

Test Plan:
- Reset, then start_i=1 with count_i=1, ready_i=1 constant -> data_o = 1,4,6,9 on 4 consecutive cycles starting 1 cycle after start; done_o pulses on the cycle after the 9 is accepted; busy_o then 0.
- count_i=2, GAP=2, ready_i=1 -> 1,4,6,9, then 2 cycles valid_o=0 with data_o=0, then 1,4,6,9, then done_o pulse; 10 busy cycles in total.
- count_i=1 with ready_i low for 3 cycles while data_o=6 -> data_o holds 6 and digit_idx_o holds 2 for those cycles; 9 follows on the cycle after ready_i rises.
- abort_i pulsed while data_o=4 with ready_i=1 -> next cycle IDLE, valid_o=0, no done_o; a new start_i with count_i=1 then sends the full sequence starting at 1.
- start_i with count_i=0 -> no valid_o; done_o=1 for exactly one cycle, 1 cycle after start.
- rst_i asserted mid-word (data_o=6) -> next cycle all outputs at reset values; start_i during busy has no effect; output stream fed to the detector reaches its final state on the 9.

Source files
------------

// File: rtl/seq_code_tx.sv
// Digit-code transmitter: streams CODE0..CODE3 over a valid/ready link, repeating the
// word a latched number of times with an optional idle gap between words.
module seq_code_tx #(
  parameter logic [3:0]  CODE0 = 4'd1,
  parameter logic [3:0]  CODE1 = 4'd4,
  parameter logic [3:0]  CODE2 = 4'd6,
  parameter logic [3:0]  CODE3 = 4'd9,
  parameter logic [3:0]  FILL  = 4'd0,
  parameter int unsigned GAP   = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] count_i,
  input  logic       abort_i,
  input  logic       ready_i,
  output logic [3:0] data_o,
  output logic       valid_o,
  output logic [1:0] digit_idx_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

  localparam logic [3:0] GapLoad = GAP[3:0];

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] words_left_q, words_left_d;
  logic [3:0] gap_q, gap_d;
  logic [3:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  function automatic logic [3:0] code_at(input logic [1:0] i);
    logic [3:0] c;
    unique case (i)
      2'd0: c = CODE0;
      2'd1: c = CODE1;
      2'd2: c = CODE2;
      2'd3: c = CODE3;
    endcase
    return c;
  endfunction

  // Next-state logic; outputs are derived from the next state so they can be registered.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    words_left_d = words_left_q;
    gap_d        = gap_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (count_i != 8'd0) begin
            words_left_d = count_i;
            idx_d        = 2'd0;
            state_d      = StSend;
          end else begin
            state_d = StDone;
          end
        end
      end
      StSend: begin
        // Abort wins over a coincident transfer: the digit is dropped.
        if (abort_i) begin
          state_d      = StIdle;
          idx_d        = 2'd0;
          words_left_d = 8'd0;
        end else if (ready_i) begin
          if (idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
          end else begin
            idx_d        = 2'd0;
            words_left_d = words_left_q - 8'd1;
            if (words_left_q == 8'd1) begin
              state_d = StDone;
            end else if (GAP == 0) begin
              state_d = StSend;
            end else begin
              gap_d   = GapLoad;
              state_d = StGap;
            end
          end
        end
      end
      StGap: begin
        if (abort_i) begin
          state_d      = StIdle;
          idx_d        = 2'd0;
          words_left_d = 8'd0;
          gap_d        = 4'd0;
        end else if (gap_q <= 4'd1) begin
          gap_d   = 4'd0;
          state_d = StSend;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    valid_d = (state_d == StSend);
    data_d  = valid_d ? code_at(idx_d) : FILL;
    busy_d  = (state_d == StSend) || (state_d == StGap);
    done_d  = (state_d == StDone);
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      idx_q        <= 2'd0;
      words_left_q <= 8'd0;
      gap_q        <= 4'd0;
      data_q       <= FILL;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      words_left_q <= words_left_d;
      gap_q        <= gap_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign digit_idx_o = idx_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_seq_code_tx.sv
// Bench for seq_code_tx: expected digits are queued when a transmission is started and
// popped on every accepted transfer.
module tb_seq_code_tx;

  localparam logic [3:0] Fill = 4'd0;

  logic       clk = 1'b0;
  logic       rst, start, abort, ready;
  logic [7:0] count;
  logic [3:0] data;
  logic       valid;
  logic [1:0] digit_idx;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  logic [5:0] exp_q[$];
  logic [5:0] exp;
  logic [3:0] code_tab[4];

  always #5 clk = ~clk;

  seq_code_tx dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .count_i     (count),
    .abort_i     (abort),
    .ready_i     (ready),
    .data_o      (data),
    .valid_o     (valid),
    .digit_idx_o (digit_idx),
    .busy_o      (busy),
    .done_o      (done)
  );

  task automatic push_words(input int n);
    for (int w = 0; w < n; w++) begin
      for (int i = 0; i < 4; i++) exp_q.push_back({2'(i), code_tab[i]});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1; count = 8'd0;
    repeat (2) @(negedge clk);
    checks++; if (data !== Fill) begin errors++; $display("FAIL reset_data got %0d required %0d", data, Fill); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b required 0", valid); end
    checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d required 0", digit_idx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b required 0", done); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int first_k = 0;
    int done_k = 0;
    push_words(1);
    start = 1'b1; count = 8'd1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid && first_k == 0) first_k = k;
      if (valid && ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL single_extra got data=%0d required none", data);
        end else begin
          exp = exp_q.pop_front();
          if ({digit_idx, data} !== exp) begin
            errors++;
            $display("FAIL single_digit got idx=%0d data=%0d required idx=%0d data=%0d",
                     digit_idx, data, exp[5:4], exp[3:0]);
          end
        end
      end
      if (done) begin done_k = k; break; end
    end
    checks++; if (first_k !== 1) begin errors++; $display("FAIL single_latency got %0d required 1", first_k); end
    checks++; if (done_k !== 5) begin errors++; $display("FAIL single_done_cycle got %0d required 5", done_k); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL single_left got %0d required 0", exp_q.size()); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL single_after got busy=%0b done=%0b required 0 0", busy, done);
    end
  endtask

  task automatic test_gap();
    int done_k = 0;
    int busy_cnt = 0;
    int gap_cnt = 0;
    push_words(2);
    start = 1'b1; count = 8'd2;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cnt++;
      if (busy && !valid) begin
        gap_cnt++;
        checks++;
        if (data !== Fill) begin errors++; $display("FAIL gap_fill got %0d required %0d", data, Fill); end
      end
      if (valid && ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL gap_extra got data=%0d required none", data);
        end else begin
          exp = exp_q.pop_front();
          if ({digit_idx, data} !== exp) begin
            errors++;
            $display("FAIL gap_digit got idx=%0d data=%0d required idx=%0d data=%0d",
                     digit_idx, data, exp[5:4], exp[3:0]);
          end
        end
      end
      if (done) begin done_k = k; break; end
    end
    checks++; if (gap_cnt !== 2) begin errors++; $display("FAIL gap_len got %0d required 2", gap_cnt); end
    checks++; if (busy_cnt !== 10) begin errors++; $display("FAIL gap_busy got %0d required 10", busy_cnt); end
    checks++; if (done_k !== 11) begin errors++; $display("FAIL gap_done_cycle got %0d required 11", done_k); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL gap_left got %0d required 0", exp_q.size()); end
    @(negedge clk);
  endtask

  task automatic test_stall();
    int done_k = 0;
    int stall_cnt = 0;
    int nine_k = 0;
    push_words(1);
    start = 1'b1; count = 8'd1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      ready = !(k >= 3 && k <= 5);
      if (valid && data == 4'd9 && nine_k == 0) nine_k = k;
      if (valid && !ready) begin
        stall_cnt++;
        checks++;
        if ({digit_idx, data} !== {2'd2, 4'd6}) begin
          errors++; $display("FAIL stall_hold got idx=%0d data=%0d required idx=2 data=6", digit_idx, data);
        end
      end
      if (valid && ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stall_extra got data=%0d required none", data);
        end else begin
          exp = exp_q.pop_front();
          if ({digit_idx, data} !== exp) begin
            errors++;
            $display("FAIL stall_digit got idx=%0d data=%0d required idx=%0d data=%0d",
                     digit_idx, data, exp[5:4], exp[3:0]);
          end
        end
      end
      if (done) begin done_k = k; break; end
    end
    ready = 1'b1;
    checks++; if (stall_cnt !== 3) begin errors++; $display("FAIL stall_cycles got %0d required 3", stall_cnt); end
    checks++; if (nine_k !== 7) begin errors++; $display("FAIL stall_nine_cycle got %0d required 7", nine_k); end
    checks++; if (done_k !== 8) begin errors++; $display("FAIL stall_done_cycle got %0d required 8", done_k); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int stray = 0;
    int done_k = 0;
    push_words(1);
    start = 1'b1; count = 8'd1;
    @(negedge clk);
    start = 1'b0;
    exp = exp_q.pop_front();
    checks++; if ({digit_idx, data} !== exp || valid !== 1'b1) begin
      errors++; $display("FAIL abort_first got valid=%0b data=%0d required 1 %0d", valid, data, exp[3:0]);
    end
    @(negedge clk);
    checks++; if (data !== 4'd4) begin errors++; $display("FAIL abort_pre got %0d required 4", data); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    exp_q.delete();
    checks++; if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_idle got valid=%0b busy=%0b done=%0b required 0 0 0", valid, busy, done);
    end
    repeat (3) begin
      @(negedge clk);
      if (valid || busy || done) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL abort_quiet got %0d required 0", stray); end
    push_words(1);
    start = 1'b1; count = 8'd1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid && ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL abort_restart_extra got data=%0d required none", data);
        end else begin
          exp = exp_q.pop_front();
          if ({digit_idx, data} !== exp) begin
            errors++;
            $display("FAIL abort_restart_digit got idx=%0d data=%0d required idx=%0d data=%0d",
                     digit_idx, data, exp[5:4], exp[3:0]);
          end
        end
      end
      if (done) begin done_k = k; break; end
    end
    checks++; if (done_k !== 5) begin errors++; $display("FAIL abort_restart_done got %0d required 5", done_k); end
    @(negedge clk);
  endtask

  task automatic test_zero();
    start = 1'b1; count = 8'd0;
    @(negedge clk);
    start = 1'b0;
    checks++; if (done !== 1'b1 || valid !== 1'b0) begin
      errors++; $display("FAIL zero_done got done=%0b valid=%0b required 1 0", done, valid);
    end
    @(negedge clk);
    checks++; if (done !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_after got done=%0b valid=%0b busy=%0b required 0 0 0", done, valid, busy);
    end
  endtask

  task automatic test_ignored_start();
    int det = 0;
    int det_at_nine = -1;
    int done_k = 0;
    int stray = 0;
    push_words(1);
    start = 1'b1; count = 8'd1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1 || k >= 4) start = 1'b0;
      if (k == 2) begin start = 1'b1; count = 8'd5; end
      if (valid && ready) begin
        if (det < 4 && data == code_tab[det]) det++;
        else det = (data == code_tab[0]) ? 1 : 0;
        if (data == 4'd9) det_at_nine = det;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL ignore_extra got data=%0d required none", data);
        end else begin
          exp = exp_q.pop_front();
          if ({digit_idx, data} !== exp) begin
            errors++;
            $display("FAIL ignore_digit got idx=%0d data=%0d required idx=%0d data=%0d",
                     digit_idx, data, exp[5:4], exp[3:0]);
          end
        end
      end
      if (done) begin done_k = k; break; end
    end
    start = 1'b0;
    checks++; if (done_k !== 5) begin errors++; $display("FAIL ignore_done got %0d required 5", done_k); end
    checks++; if (det_at_nine !== 4) begin errors++; $display("FAIL detector_final got %0d required 4", det_at_nine); end
    repeat (4) begin
      @(negedge clk);
      if (valid || busy) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL ignore_no_restart got %0d required 0", stray); end
  endtask

  task automatic test_reset_mid();
    push_words(3);
    start = 1'b1; count = 8'd3;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k < 3 && valid && ready) begin
        checks++;
        exp = exp_q.pop_front();
        if ({digit_idx, data} !== exp) begin
          errors++;
          $display("FAIL rstmid_digit got idx=%0d data=%0d required idx=%0d data=%0d",
                   digit_idx, data, exp[5:4], exp[3:0]);
        end
      end
    end
    checks++; if (data !== 4'd6) begin errors++; $display("FAIL rstmid_pre got %0d required 6", data); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    checks++; if (data !== Fill || valid !== 1'b0 || digit_idx !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs got data=%0d valid=%0b idx=%0d busy=%0b done=%0b required 0 0 0 0 0",
               data, valid, digit_idx, busy, done);
    end
    @(negedge clk);
    checks++; if (valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_stay_idle got valid=%0b busy=%0b required 0 0", valid, busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    code_tab[0] = 4'd1; code_tab[1] = 4'd4; code_tab[2] = 4'd6; code_tab[3] = 4'd9;
    test_reset();
    test_single();
    test_gap();
    test_stall();
    test_abort();
    test_zero();
    test_ignored_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
